// File: rtl/mul_pipe_param.sv
// Fully pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready handshake and passthrough tag.
// Optional MUL_FLUSH_EN adds flush_i, which empties the pipe in one cycle.
module mul_pipe_param #(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 4,
  parameter int STAGES  = 3,
  parameter int TAG_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [XLEN-1:0]  in_a_i,
  input  logic [XLEN-1:0]  in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_result_o,
  output logic [TAG_W-1:0] out_tag_o
`ifdef MUL_FLUSH_EN
  ,
  input  logic             flush_i
`endif
);

  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} op_e;

  localparam int ND  = XLEN / DIGIT_W;
  localparam int NC  = 2 * ND - 1;
  localparam int CW  = 2 * DIGIT_W + $clog2(ND) + 1;
  localparam int PW  = 2 * XLEN;
  localparam int MID = STAGES - 2;

  logic [STAGES:1] vld;
  logic [STAGES:1] adv;
  op_e             op_q  [1:STAGES];
  logic [TAG_W-1:0] tag_q [1:STAGES];
  logic            room;
  logic            flush;
  logic            accept;

  logic [XLEN-1:0] a_q, b_q;
  logic            as_q, bs_q;
  logic [CW-1:0]   col_c   [NC];
  logic [PW-1:0]   corr_c;
  logic [CW-1:0]   fin_col [NC];
  logic [PW-1:0]   fin_corr;
  logic [PW-1:0]   sum_c;
  logic [XLEN-1:0] res_c;
  logic [XLEN-1:0] res_q;

`ifdef MUL_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Walk from the output back to S1: a stage moves when the stage ahead has room.
  always_comb begin
    adv  = '0;
    room = out_ready_i;
    for (int k = STAGES; k >= 1; k--) begin
      adv[k] = vld[k] & room;
      room   = ~vld[k] | adv[k];
    end
  end

  assign in_ready_o = room & ~flush;
  assign accept     = in_valid_i & in_ready_o;

  function automatic logic [CW-1:0] digit(input logic [XLEN-1:0] v, input int idx);
    return CW'(v[idx*DIGIT_W +: DIGIT_W]);
  endfunction

  // Unsigned digit products summed per column; the extension bits become a correction term.
  always_comb begin
    for (int c = 0; c < NC; c++) col_c[c] = '0;
    for (int i = 0; i < ND; i++)
      for (int j = 0; j < ND; j++)
        col_c[i+j] = col_c[i+j] + digit(a_q, i) * digit(b_q, j);
    corr_c = '0;
    if (as_q) corr_c = corr_c - {b_q, {XLEN{1'b0}}};
    if (bs_q) corr_c = corr_c - {a_q, {XLEN{1'b0}}};
  end

  generate
    if (MID == 0) begin : g_direct
      assign fin_col  = col_c;
      assign fin_corr = corr_c;
    end else begin : g_mid
      logic [CW-1:0] col_m  [MID][NC];
      logic [PW-1:0] corr_m [MID];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int m = 0; m < MID; m++) begin
            for (int c = 0; c < NC; c++) col_m[m][c] <= '0;
            corr_m[m] <= '0;
          end
        end else begin
          if (adv[1]) begin
            col_m[0]  <= col_c;
            corr_m[0] <= corr_c;
          end
          for (int m = 1; m < MID; m++) begin
            if (adv[m+1]) begin
              col_m[m]  <= col_m[m-1];
              corr_m[m] <= corr_m[m-1];
            end
          end
        end
      end

      assign fin_col  = col_m[MID-1];
      assign fin_corr = corr_m[MID-1];
    end
  endgenerate

  // The 2^(2*XLEN) sign term falls outside the returned bits, so the sum stays 2*XLEN wide.
  always_comb begin
    sum_c = fin_corr;
    for (int c = 0; c < NC; c++) sum_c = sum_c + (PW'(fin_col[c]) << (c * DIGIT_W));
    res_c = (op_q[STAGES-1] == OP_MUL) ? sum_c[XLEN-1:0] : sum_c[PW-1:XLEN];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        op_q[k]  <= OP_MUL;
        tag_q[k] <= '0;
      end
      a_q   <= '0;
      b_q   <= '0;
      as_q  <= 1'b0;
      bs_q  <= 1'b0;
      res_q <= '0;
    end else begin
      if (accept) begin
        vld[1]   <= 1'b1;
        op_q[1]  <= op_e'(in_op_i);
        tag_q[1] <= in_tag_i;
        a_q      <= in_a_i;
        b_q      <= in_b_i;
        as_q     <= in_a_i[XLEN-1] & ((in_op_i == OP_MULH) | (in_op_i == OP_MULHSU));
        bs_q     <= in_b_i[XLEN-1] & (in_op_i == OP_MULH);
      end else if (adv[1]) begin
        vld[1] <= 1'b0;
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (adv[k-1]) begin
          vld[k]   <= 1'b1;
          op_q[k]  <= op_q[k-1];
          tag_q[k] <= tag_q[k-1];
        end else if (adv[k]) begin
          vld[k] <= 1'b0;
        end
      end
      if (adv[STAGES-1]) res_q <= res_c;
      if (flush) vld <= '0;
    end
  end

  assign out_valid_o  = vld[STAGES];
  assign out_tag_o    = tag_q[STAGES];
  assign out_result_o = res_q;

endmodule

// File: tb/tb_mul_pipe_param.sv
// Self-checking bench for mul_pipe_param: queue-based reference model plus directed literal vectors.
module tb_mul_pipe_param;

  localparam int STAGES   = 3;
  localparam int STAGES64 = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;
  logic        flush;

  logic        v64, rdy64, ov64, ordy64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, res64;
  logic [4:0]  tag64, otag64;

  always #5 clk = ~clk;

  mul_pipe_param dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
    .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_result_o(out_result), .out_tag_o(out_tag)
`ifdef MUL_FLUSH_EN
    , .flush_i(flush)
`endif
  );

  mul_pipe_param #(.XLEN(64), .DIGIT_W(8), .STAGES(STAGES64), .TAG_W(5)) dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(v64), .in_ready_o(rdy64), .in_op_i(op64),
    .in_a_i(a64), .in_b_i(b64), .in_tag_i(tag64),
    .out_valid_o(ov64), .out_ready_i(ordy64),
    .out_result_o(res64), .out_tag_o(otag64)
`ifdef MUL_FLUSH_EN
    , .flush_i(1'b0)
`endif
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          drained = 0;
  int          accept_count = 0;
  int          block_at = -1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res = '0;
  logic [4:0]  prev_tag = '0;

  // Reference: extend to 66 bits, multiply with plain signed arithmetic, pick the half.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ae, be, p;
    ae = {{34{a[31] & (op == 2'd1 || op == 2'd2)}}, a};
    be = {{34{b[31] & (op == 2'd1)}}, b};
    p  = ae * be;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Compare process: output side against the model queue, then record new accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      prev_stall = 1'b0;
      check("reset_out_valid", {63'b0, out_valid}, 64'd0);
      check("reset_out_result", {32'b0, out_result}, 64'd0);
      check("reset_out_tag", {59'b0, out_tag}, 64'd0);
    end else begin
      if (prev_stall) begin
        check("stall_valid", {63'b0, out_valid}, 64'd1);
        check("stall_result", {32'b0, out_result}, {32'b0, prev_res});
        check("stall_tag", {59'b0, out_tag}, {59'b0, prev_tag});
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result actual tag=%0d expected no output", out_tag);
        end else begin
          check("model_result", {32'b0, out_result}, {32'b0, expq[0].res});
          check("model_tag", {59'b0, out_tag}, {59'b0, expq[0].tag});
          if (out_ready) begin
            void'(expq.pop_front());
            drained++;
          end
        end
      end
      prev_stall = out_valid & ~out_ready & ~flush;
      prev_res   = out_result;
      prev_tag   = out_tag;
      if (flush) expq.delete();
      if (in_valid && in_ready) begin
        expq.push_back({model(in_op, in_a, in_b), in_tag});
        accept_count++;
      end
    end
  end

  // Offer one op and hold it until accepted; operands are scrambled right after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    n = 0;
    forever begin
      @(negedge clk);
      if (!in_ready && block_at < 0) block_at = accept_count;
      if (in_ready) break;
      n++;
      if (n > 60) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h0BAD_F00D;
  endtask

  // Called just after the accept edge with out_ready high: result must appear exactly STAGES cycles later.
  task automatic checkOutput(input string name, input logic [31:0] exp_res, input logic [4:0] exp_tag);
    for (int i = 1; i < STAGES; i++) begin
      @(negedge clk);
      check({name, "_early"}, {63'b0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check({name, "_valid"}, {63'b0, out_valid}, 64'd1);
    check({name, "_result"}, {32'b0, out_result}, {32'b0, exp_res});
    check({name, "_tag"}, {59'b0, out_tag}, {59'b0, exp_tag});
    @(posedge clk);
    #1;
  endtask

  task automatic run64(input string name, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    v64 = 1'b1; op64 = op; a64 = a; b64 = b; tag64 = 5'd9;
    @(negedge clk);
    check({name, "_ready"}, {63'b0, rdy64}, 64'd1);
    @(posedge clk);
    #1;
    v64 = 1'b0; a64 = '0; b64 = '0;
    for (int i = 1; i < STAGES64; i++) begin
      @(negedge clk);
      check({name, "_early"}, {63'b0, ov64}, 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check({name, "_valid"}, {63'b0, ov64}, 64'd1);
    check({name, "_result"}, res64, exp);
    check({name, "_tag"}, {59'b0, otag64}, 64'd9);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1; flush = 1'b0;
    v64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; tag64 = '0; ordy64 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    applyStimulus(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    checkOutput("mulhu_max", 32'hFFFF_FFFE, 5'd3);
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    checkOutput("mul_max", 32'h0000_0001, 5'd4);
    applyStimulus(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd5);
    checkOutput("mulh_minmin", 32'h4000_0000, 5'd5);
    applyStimulus(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    checkOutput("mulhsu_m1", 32'hFFFF_FFFF, 5'd6);
    applyStimulus(2'd1, 32'hFFFF_FFFF, 32'd7, 5'd7);
    checkOutput("mulh_neg7", 32'hFFFF_FFFF, 5'd7);
    applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    checkOutput("mulhsu_min", 32'h8000_0000, 5'd8);
    applyStimulus(2'd1, 32'd0, 32'h8000_0000, 5'd9);
    checkOutput("mulh_zero", 32'd0, 5'd9);
    applyStimulus(2'd0, 32'h1234_5678, 32'd0, 5'd10);
    checkOutput("mul_zero", 32'd0, 5'd10);

    // Eight back-to-back ops while the consumer stalls for five cycles.
    out_ready = 1'b0;
    block_at  = -1;
    accept_count = 0;
    drained   = 0;
    fork
      begin
        for (int t = 0; t < 8; t++)
          applyStimulus(2'(t % 4), 32'h9E37_79B9 * (t + 1), 32'hF00D_0000 ^ (t * 32'h0101_0307), 5'(t));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 40 && drained < 8; n++) @(posedge clk);
    #1;
    check("stall_block_point", 64'(block_at), 64'(STAGES));
    check("drained_count", 64'(drained), 64'd8);

    // Reset while two ops are in flight.
    applyStimulus(2'd0, 32'd5, 32'd6, 5'd20);
    applyStimulus(2'd0, 32'd7, 32'd8, 5'd21);
    rst_n = 1'b0;
    #1;
    check("reset_async_valid", {63'b0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_idle", {63'b0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(2'd0, 32'd9, 32'd11, 5'd22);
    checkOutput("after_reset", 32'd99, 5'd22);

`ifdef MUL_FLUSH_EN
    out_ready = 1'b0;
    applyStimulus(2'd0, 32'd2, 32'd3, 5'd23);
    applyStimulus(2'd0, 32'd4, 32'd5, 5'd24);
    applyStimulus(2'd0, 32'd6, 32'd7, 5'd25);
    flush = 1'b1; in_valid = 1'b1; in_op = 2'd0; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd26;
    @(negedge clk);
    check("flush_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    repeat (6) @(posedge clk);
    #1;
`endif

    run64("mulhu64", 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
    run64("mul64", 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run64("mulh64_minmin", 2'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
